pg_sequencer: RTL and testbench

Power-rail sequencer that sits directly downstream of the power-good AND stage. It synchronizes and debounces the combined power-good signal, then brings rails up in order on request. It monitors power-good while the rails are up and shuts them down in reverse order on request. On a timeout or loss of power-good it forces every rail off and latches a fault.

---
 rtl/pg_seq_pkg.sv | 17 +
 rtl/pg_debounce.sv | 43 ++++
 rtl/pg_sequencer.sv | 149 ++++++++++++++
 tb/tb_pg_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pg_seq_pkg.sv
// Shared types and constants for the power-rail sequencer.
package pg_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF  = 2'd0,
        ST_RAMP = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } pg_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pg_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for an async level.
module pg_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_db
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic              sync_q;
    logic              d_s;
    logic [DCNT_W-1:0] dcnt;

    // Metastability guard for the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            d_s    <= 1'b0;
        end else begin
            sync_q <= d_in;
            d_s    <= sync_q;
        end
    end

    // Accept a new level only after it has held for DEBOUNCE_CYC cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_db <= 1'b0;
            dcnt <= '0;
        end else if (d_s == d_db) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_W'(DEBOUNCE_CYC - 1)) begin
            d_db <= d_s;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DCNT_W'(1);
        end
    end

endmodule

// File: rtl/pg_sequencer.sv
// Power-rail sequencer: ordered ramp-up, reverse ramp-down, timeout and power-good loss faults.
module pg_sequencer
    import pg_seq_pkg::*;
#(
    parameter int unsigned N_RAILS      = 3,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned STEP_DLY     = 8,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pg_in,
    input  logic               en_req,
    output logic [N_RAILS-1:0] rail_en,
    output logic               pwr_good,
    output logic               fault,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned RAIL_W = N_RAILS;
    localparam int unsigned CNT_W  = $clog2(max_u(STEP_DLY, TIMEOUT_CYC) + 1);

    pg_state_e         state, state_nx;
    logic [RAIL_W-1:0] rail_nx;
    logic [RAIL_W-1:0] rail_up;
    logic [RAIL_W-1:0] rail_dn;
    logic              pwr_nx;
    logic              fault_nx;
    logic [CNT_W-1:0]  scnt, scnt_nx;
    logic              pg_db;
    logic              all_on;
    logic              step_done;
    logic              tmo_done;

    pg_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (pg_in),
        .d_db (pg_db)
    );

    // Rails form a thermometer code from bit 0, so shifts add/remove the top rail
    assign rail_up   = RAIL_W'({rail_en, 1'b1});
    assign rail_dn   = rail_en >> 1;
    assign all_on    = &rail_en;
    assign step_done = (scnt == CNT_W'(STEP_DLY - 1));
    assign tmo_done  = (scnt == CNT_W'(TIMEOUT_CYC - 1));
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            rail_en  <= '0;
            pwr_good <= 1'b0;
            fault    <= 1'b0;
            scnt     <= '0;
        end else begin
            state    <= state_nx;
            rail_en  <= rail_nx;
            pwr_good <= pwr_nx;
            fault    <= fault_nx;
            scnt     <= scnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rail_nx  = rail_en;
        pwr_nx   = 1'b0;
        fault_nx = fault;
        scnt_nx  = scnt;

        case (state)
            ST_OFF: begin
                rail_nx = '0;
                if (fault && !en_req) begin
                    fault_nx = 1'b0;
                end else if (en_req && !fault) begin
                    state_nx = ST_RAMP;
                    rail_nx  = RAIL_W'(1);
                    scnt_nx  = '0;
                end
            end

            ST_RAMP: begin
                if (all_on && tmo_done) begin
                    // Timeout wins over a power-good arriving on the same edge
                    state_nx = ST_OFF;
                    rail_nx  = '0;
                    fault_nx = 1'b1;
                    scnt_nx  = '0;
                end else if (!en_req) begin
                    state_nx = (rail_dn == '0) ? ST_OFF : ST_DOWN;
                    rail_nx  = rail_dn;
                    scnt_nx  = '0;
                end else if (all_on && pg_db) begin
                    state_nx = ST_ON;
                    pwr_nx   = 1'b1;
                    scnt_nx  = '0;
                end else if (!all_on && step_done) begin
                    rail_nx = rail_up;
                    scnt_nx = '0;
                end else begin
                    scnt_nx = scnt + CNT_W'(1);
                end
            end

            ST_ON: begin
                pwr_nx = 1'b1;
                if (!pg_db) begin
                    state_nx = ST_OFF;
                    rail_nx  = '0;
                    pwr_nx   = 1'b0;
                    fault_nx = 1'b1;
                    scnt_nx  = '0;
                end else if (!en_req) begin
                    state_nx = (rail_dn == '0) ? ST_OFF : ST_DOWN;
                    rail_nx  = rail_dn;
                    pwr_nx   = 1'b0;
                    scnt_nx  = '0;
                end
            end

            ST_DOWN: begin
                if (rail_en == '0) begin
                    state_nx = ST_OFF;
                    scnt_nx  = '0;
                end else if (step_done) begin
                    rail_nx  = rail_dn;
                    scnt_nx  = '0;
                    if (rail_dn == '0) begin
                        state_nx = ST_OFF;
                    end
                end else begin
                    scnt_nx = scnt + CNT_W'(1);
                end
            end

            default: begin
                state_nx = ST_OFF;
                rail_nx  = '0;
                scnt_nx  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pg_sequencer.sv
// Scoreboard bench for pg_sequencer: expectations queued at stimulus time, checked per cycle.
module tb_pg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pg_in;
    logic       en_req;
    logic [2:0] rail_en;
    logic       pwr_good;
    logic       fault;
    logic [1:0] state_o;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] rail;
        logic       pg;
        logic       flt;
        logic [1:0] st;
        bit         chk_st;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    pg_sequencer #(
        .N_RAILS     (3),
        .DEBOUNCE_CYC(4),
        .STEP_DLY    (3),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pg_in   (pg_in),
        .en_req  (en_req),
        .rail_en (rail_en),
        .pwr_good(pwr_good),
        .fault   (fault),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp_v);
        end
    endtask

    task automatic push_exp(input int c, input string tag, input logic [2:0] rail,
                            input logic pg, input logic flt, input logic [1:0] st,
                            input bit chk_st);
        exp_t e;
        e.cyc    = c;
        e.tag    = tag;
        e.rail   = rail;
        e.pg     = pg;
        e.flt    = flt;
        e.st     = st;
        e.chk_st = chk_st;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare every expectation due at or before the current edge
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e_mon = sb.pop_front();
            chk({e_mon.tag, "_cyc"}, 32'(cyc), 32'(e_mon.cyc));
            chk({e_mon.tag, "_rail"}, 32'(rail_en), 32'(e_mon.rail));
            chk({e_mon.tag, "_pg"}, 32'(pwr_good), 32'(e_mon.pg));
            chk({e_mon.tag, "_fault"}, 32'(fault), 32'(e_mon.flt));
            if (e_mon.chk_st) chk({e_mon.tag, "_state"}, 32'(state_o), 32'(e_mon.st));
        end
    end

    initial begin
        int t;
        rst_n  = 1'b0;
        pg_in  = 1'b0;
        en_req = 1'b0;
        step(2);
        chk("rst_rail", 32'(rail_en), 32'd0);
        chk("rst_pg", 32'(pwr_good), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Power-up sequence
        t = cyc;
        en_req = 1'b1;
        push_exp(t + 1, "up_r0", 3'b001, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 3, "up_r0h", 3'b001, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 4, "up_r1", 3'b011, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 6, "up_r1h", 3'b011, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 7, "up_r2", 3'b111, 1'b0, 1'b0, 2'd1, 1'b1);
        step(8);
        pg_in = 1'b1;
        push_exp(t + 14, "up_wait", 3'b111, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 15, "up_on", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        step(12);

        // 3-cycle glitch is rejected
        t = cyc;
        pg_in = 1'b0;
        push_exp(t + 4, "gl3_a", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        push_exp(t + 7, "gl3_b", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        push_exp(t + 8, "gl3_c", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        step(3);
        pg_in = 1'b1;
        step(9);

        // 4-cycle drop is a fault, then cleared by en_req low
        t = cyc;
        pg_in = 1'b0;
        push_exp(t + 6, "gl4_pre", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        push_exp(t + 7, "gl4_flt", 3'b000, 1'b0, 1'b1, 2'd0, 1'b1);
        push_exp(t + 9, "flt_hold", 3'b000, 1'b0, 1'b1, 2'd0, 1'b1);
        step(4);
        pg_in = 1'b1;
        step(6);
        t = cyc;
        en_req = 1'b0;
        push_exp(t + 1, "flt_clr", 3'b000, 1'b0, 1'b0, 2'd0, 1'b1);
        step(3);

        // Timeout with power-good held low
        pg_in = 1'b0;
        step(10);
        t = cyc;
        en_req = 1'b1;
        push_exp(t + 1, "to_r0", 3'b001, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 4, "to_r1", 3'b011, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 7, "to_r2", 3'b111, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 16, "to_pre", 3'b111, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 17, "to_flt", 3'b000, 1'b0, 1'b1, 2'd0, 1'b1);
        step(20);
        t = cyc;
        en_req = 1'b0;
        push_exp(t + 1, "to_clr", 3'b000, 1'b0, 1'b0, 2'd0, 1'b1);
        step(3);

        // Orderly power-down; a mid-DOWN request is ignored
        pg_in = 1'b1;
        step(10);
        t = cyc;
        en_req = 1'b1;
        push_exp(t + 1, "pd_r0", 3'b001, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 4, "pd_r1", 3'b011, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 7, "pd_r2", 3'b111, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 8, "pd_on", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        step(10);
        t = cyc;
        en_req = 1'b0;
        push_exp(t + 1, "pd_d1", 3'b011, 1'b0, 1'b0, 2'd3, 1'b1);
        push_exp(t + 3, "pd_d1h", 3'b011, 1'b0, 1'b0, 2'd3, 1'b1);
        push_exp(t + 4, "pd_d2", 3'b001, 1'b0, 1'b0, 2'd3, 1'b1);
        push_exp(t + 6, "pd_d2h", 3'b001, 1'b0, 1'b0, 2'd3, 1'b1);
        push_exp(t + 7, "pd_d3", 3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
        push_exp(t + 10, "pd_off", 3'b000, 1'b0, 1'b0, 2'd0, 1'b1);
        step(2);
        en_req = 1'b1;
        step(3);
        en_req = 1'b0;
        step(6);

        // Power-good fall and en_req fall on the same edge: fault wins
        t = cyc;
        en_req = 1'b1;
        push_exp(t + 8, "sim_on", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        step(10);
        t = cyc;
        pg_in = 1'b0;
        push_exp(t + 6, "sim_pre", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        step(6);
        en_req = 1'b0;
        push_exp(t + 7, "sim_flt", 3'b000, 1'b0, 1'b1, 2'd0, 1'b1);
        push_exp(t + 8, "sim_clr", 3'b000, 1'b0, 1'b0, 2'd0, 1'b1);
        step(4);

        // Asynchronous reset mid-ramp, then a clean restart
        pg_in = 1'b1;
        step(8);
        t = cyc;
        en_req = 1'b1;
        push_exp(t + 4, "mr_r1", 3'b011, 1'b0, 1'b0, 2'd1, 1'b1);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rail", 32'(rail_en), 32'd0);
        chk("mr_pg", 32'(pwr_good), 32'd0);
        chk("mr_fault", 32'(fault), 32'd0);
        chk("mr_state", 32'(state_o), 32'd0);
        step(1);
        t = cyc;
        rst_n = 1'b1;
        push_exp(t + 1, "rs_r0", 3'b001, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 4, "rs_r1", 3'b011, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 7, "rs_r2", 3'b111, 1'b0, 1'b0, 2'd1, 1'b1);
        push_exp(t + 8, "rs_on", 3'b111, 1'b1, 1'b0, 2'd2, 1'b1);
        step(10);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
